// File: rtl/csr_trap_unit.sv
// csr_trap_unit
// Commit-side CSR file and trap sequencer. It owns the machine/supervisor
// CSRs and the privilege mode. It commits CSR writes from the retiring
// instruction, enters traps, and executes mret. On a trap or mret it issues
// a one-cycle redirect/flush pulse to fetch.
//
// Ports:
//   clk, reset          core clock, asynchronous active-low reset
//   commit_*            retiring instruction (valid, pc, raw bits)
//   csr_we/waddr/wdata  committed CSR write (set/clear resolved upstream)
//   excep_en/cause/tval exception raised by the retiring instruction
//   mret                retiring instruction is mret
//   csr_raddr/rdata     combinational decode-side CSR read
//   priv_mode           current privilege mode
//   redirect_valid/pc   one-cycle flush pulse and its target
//   satp_out            current satp for translation
module csr_trap_unit #(
    parameter logic [63:0] HARTID        = 64'd0,
    parameter logic [1:0]  RESET_PC_MODE = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [31:0] commit_instr,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [63:0] csr_wdata,
    input  logic        excep_en,
    input  logic [63:0] excep_cause,
    input  logic [63:0] excep_tval,
    input  logic        mret,
    input  logic [11:0] csr_raddr,
    output logic [63:0] csr_rdata,
    output logic [1:0]  priv_mode,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [63:0] satp_out
);

    localparam logic [11:0] CSR_SSTATUS  = 12'h100;
    localparam logic [11:0] CSR_STVEC    = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH = 12'h140;
    localparam logic [11:0] CSR_SEPC     = 12'h141;
    localparam logic [11:0] CSR_SCAUSE   = 12'h142;
    localparam logic [11:0] CSR_STVAL    = 12'h143;
    localparam logic [11:0] CSR_SATP     = 12'h180;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MEDELEG  = 12'h302;
    localparam logic [11:0] CSR_MIDELEG  = 12'h303;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hb00;
    localparam logic [11:0] CSR_MHARTID  = 12'hf14;

    localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_007e_79bb;
    localparam logic [63:0] SSTATUS_RMASK = 64'h8000_0003_0001_e000;
    // sstatus write mask is the read mask without sd (sd is derived, never stored)
    localparam logic [63:0] SSTATUS_WMASK = 64'h0000_0003_0001_e000;
    localparam logic [63:0] MIP_MASK      = 64'h0000_0000_0000_0333;
    localparam logic [1:0]  MODE_U        = 2'b00;
    localparam logic [1:0]  MODE_M        = 2'b11;

    // Architectural mstatus view: stored bit 63 is always 0, sd is derived from fs/xs.
    function automatic logic [63:0] mstatus_view(input logic [63:0] raw);
        logic sd;
        sd = (raw[14:13] == 2'b11) || (raw[16:15] == 2'b11);
        return {sd, raw[62:0]};
    endfunction

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d;
    logic [63:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] stvec_q, stvec_d;
    logic [63:0] sscratch_q, sscratch_d;
    logic [63:0] sepc_q, sepc_d;
    logic [63:0] scause_q, scause_d;
    logic [63:0] stval_q, stval_d;
    logic [63:0] satp_q, satp_d;
    logic [1:0]  priv_q, priv_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [63:0] redirect_pc_q, redirect_pc_d;

    logic        accept_s;
    logic        priv_fault_s;
    logic        take_trap_s;
    logic        take_mret_s;
    logic        do_write_s;
    logic [63:0] trap_cause_s;
    logic [63:0] trap_tval_s;

    // The slot under a redirect is being flushed, so nothing is accepted then.
    assign accept_s     = commit_valid && !redirect_valid_q;
    assign priv_fault_s = csr_we && (csr_waddr[9:8] > priv_q);
    assign take_trap_s  = accept_s && (excep_en || priv_fault_s);
    assign take_mret_s  = accept_s && !take_trap_s && mret;
    assign do_write_s   = accept_s && !take_trap_s && !mret && csr_we;
    // An exception raised by the instruction itself outranks the privilege fault.
    assign trap_cause_s = excep_en ? excep_cause : 64'd2;
    assign trap_tval_s  = excep_en ? excep_tval : {32'd0, commit_instr};

    // Next-state logic: trap, then mret, then CSR write; mcycle counts otherwise.
    always_comb begin
        mstatus_d        = mstatus_q;
        mie_d            = mie_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mip_d            = mip_q;
        mcycle_d         = mcycle_q + 64'd1;
        stvec_d          = stvec_q;
        sscratch_d       = sscratch_q;
        sepc_d           = sepc_q;
        scause_d         = scause_q;
        stval_d          = stval_q;
        satp_d           = satp_q;
        priv_d           = priv_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (take_trap_s) begin
            mepc_d             = commit_pc;
            mcause_d           = trap_cause_s;
            mtval_d            = trap_tval_s;
            mstatus_d[7]       = mstatus_q[3];
            mstatus_d[3]       = 1'b0;
            mstatus_d[12:11]   = priv_q;
            priv_d             = MODE_M;
            redirect_valid_d   = 1'b1;
            redirect_pc_d      = {mtvec_q[63:2], 2'b00};
        end else if (take_mret_s) begin
            priv_d             = mstatus_q[12:11];
            mstatus_d[3]       = mstatus_q[7];
            mstatus_d[7]       = 1'b1;
            mstatus_d[12:11]   = MODE_U;
            redirect_valid_d   = 1'b1;
            redirect_pc_d      = mepc_q;
        end else if (do_write_s) begin
            case (csr_waddr)
                CSR_MSTATUS:  mstatus_d  = (mstatus_q & ~MSTATUS_WMASK) | (csr_wdata & MSTATUS_WMASK);
                CSR_SSTATUS:  mstatus_d  = (mstatus_q & ~SSTATUS_WMASK) | (csr_wdata & SSTATUS_WMASK);
                CSR_MTVEC:    mtvec_d    = csr_wdata & ~64'd2;
                CSR_MIP:      mip_d      = csr_wdata & MIP_MASK;
                CSR_MIE:      mie_d      = csr_wdata;
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_MEPC:     mepc_d     = csr_wdata;
                CSR_MCAUSE:   mcause_d   = csr_wdata;
                CSR_MTVAL:    mtval_d    = csr_wdata;
                CSR_MCYCLE:   mcycle_d   = csr_wdata;
                CSR_STVEC:    stvec_d    = csr_wdata;
                CSR_SSCRATCH: sscratch_d = csr_wdata;
                CSR_SEPC:     sepc_d     = csr_wdata;
                CSR_SCAUSE:   scause_d   = csr_wdata;
                CSR_STVAL:    stval_d    = csr_wdata;
                CSR_SATP:     satp_d     = csr_wdata;
                default:      mscratch_d = mscratch_q;  // medeleg/mideleg and unimplemented: ignored
            endcase
        end else begin
            redirect_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_q        <= 64'd0;
            mie_q            <= 64'd0;
            mtvec_q          <= 64'd0;
            mscratch_q       <= 64'd0;
            mepc_q           <= 64'd0;
            mcause_q         <= 64'd0;
            mtval_q          <= 64'd0;
            mip_q            <= 64'd0;
            mcycle_q         <= 64'd0;
            stvec_q          <= 64'd0;
            sscratch_q       <= 64'd0;
            sepc_q           <= 64'd0;
            scause_q         <= 64'd0;
            stval_q          <= 64'd0;
            satp_q           <= 64'd0;
            priv_q           <= RESET_PC_MODE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'd0;
        end else begin
            mstatus_q        <= mstatus_d;
            mie_q            <= mie_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mip_q            <= mip_d;
            mcycle_q         <= mcycle_d;
            stvec_q          <= stvec_d;
            sscratch_q       <= sscratch_d;
            sepc_q           <= sepc_d;
            scause_q         <= scause_d;
            stval_q          <= stval_d;
            satp_q           <= satp_d;
            priv_q           <= priv_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Decode-side read mux; returns pre-commit values (no forwarding here).
    always_comb begin
        csr_rdata = 64'd0;
        case (csr_raddr)
            CSR_MSTATUS:  csr_rdata = mstatus_view(mstatus_q);
            CSR_SSTATUS:  csr_rdata = mstatus_view(mstatus_q) & SSTATUS_RMASK;
            CSR_MEDELEG:  csr_rdata = 64'd0;
            CSR_MIDELEG:  csr_rdata = 64'd0;
            CSR_MIE:      csr_rdata = mie_q;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MIP:      csr_rdata = mip_q & MIP_MASK;
            CSR_MCYCLE:   csr_rdata = mcycle_q;
            CSR_MHARTID:  csr_rdata = HARTID;
            CSR_STVEC:    csr_rdata = stvec_q;
            CSR_SSCRATCH: csr_rdata = sscratch_q;
            CSR_SEPC:     csr_rdata = sepc_q;
            CSR_SCAUSE:   csr_rdata = scause_q;
            CSR_STVAL:    csr_rdata = stval_q;
            CSR_SATP:     csr_rdata = satp_q;
            default:      csr_rdata = 64'd0;
        endcase
    end

    assign priv_mode      = priv_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign satp_out       = satp_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit
// Self-checking bench for csr_trap_unit: directed scenarios with literal
// expectations, then randomized commits checked every cycle against a
// behavioural CSR-file model held in an associative array.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_instr;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        excep_en;
    logic [63:0] excep_cause;
    logic [63:0] excep_tval;
    logic        mret;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic [1:0]  priv_mode;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] satp_out;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [63:0] mdl [logic [11:0]];
    logic [1:0]  m_priv;
    logic        m_rv;
    logic [63:0] m_rpc;

    logic [11:0] addr_tbl [20] = '{12'h100, 12'h105, 12'h140, 12'h141, 12'h142,
                                   12'h143, 12'h180, 12'h300, 12'h302, 12'h303,
                                   12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'hb00, 12'hf14, 12'h7c0};

    csr_trap_unit dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .excep_en(excep_en), .excep_cause(excep_cause), .excep_tval(excep_tval),
        .mret(mret), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .priv_mode(priv_mode), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .satp_out(satp_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mget(input logic [11:0] a);
        return mdl.exists(a) ? mdl[a] : 64'd0;
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        logic [63:0] v;
        v = mget(12'h300);
        if (v[14:13] == 2'd3 || v[16:15] == 2'd3) v[63] = 1'b1;
        case (a)
            12'h300: return v;
            12'h100: return v & 64'h8000_0003_0001_e000;
            12'h344: return mget(a) & 64'h333;
            12'hf14: return 64'd0;
            default: return mget(a);
        endcase
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [63:0] d);
        logic [63:0] ms;
        ms = mget(12'h300);
        case (a)
            12'h300: mdl[12'h300] = (ms & ~64'h7e79bb) | (d & 64'h7e79bb);
            12'h100: mdl[12'h300] = (ms & ~64'h3_0001_e000) | (d & 64'h3_0001_e000);
            12'h305: mdl[a] = d & ~64'd2;
            12'h344: mdl[a] = d & 64'h333;
            12'h304, 12'h340, 12'h341, 12'h342, 12'h343,
            12'h105, 12'h140, 12'h141, 12'h142, 12'h143, 12'h180: mdl[a] = d;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        mdl.delete();
        m_priv = 2'd3;
        m_rv   = 1'b0;
        m_rpc  = 64'd0;
    endtask

    // One clock edge of the architectural rules, using pre-edge state.
    task automatic model_step();
        logic [63:0] ms, cyc;
        logic acc, fault, rv_n;
        logic [63:0] rpc_n;
        rv_n  = 1'b0;
        rpc_n = m_rpc;
        cyc   = mget(12'hb00) + 64'd1;
        acc   = commit_valid && !m_rv;
        fault = csr_we && (csr_waddr[9:8] > m_priv);
        ms    = mget(12'h300);
        if (acc && (excep_en || fault)) begin
            mdl[12'h341] = commit_pc;
            mdl[12'h342] = excep_en ? excep_cause : 64'd2;
            mdl[12'h343] = excep_en ? excep_tval : {32'd0, commit_instr};
            ms[7] = ms[3];
            ms[3] = 1'b0;
            ms[12:11] = m_priv;
            mdl[12'h300] = ms;
            m_priv = 2'd3;
            rv_n   = 1'b1;
            rpc_n  = mget(12'h305) & ~64'd3;
        end else if (acc && mret) begin
            rpc_n  = mget(12'h341);
            m_priv = ms[12:11];
            ms[3]  = ms[7];
            ms[7]  = 1'b1;
            ms[12:11] = 2'd0;
            mdl[12'h300] = ms;
            rv_n   = 1'b1;
        end else if (acc && csr_we) begin
            if (csr_waddr == 12'hb00) cyc = csr_wdata;
            else model_write(csr_waddr, csr_wdata);
        end
        mdl[12'hb00] = cyc;
        m_rv  = rv_n;
        m_rpc = rpc_n;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("priv_mode", {62'd0, priv_mode}, {62'd0, m_priv});
            check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
            if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
            check("satp_out", satp_out, mget(12'h180));
            check("csr_rdata", csr_rdata, model_read(csr_raddr));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        commit_valid = 1'b0; csr_we = 1'b0; excep_en = 1'b0; mret = 1'b0;
        csr_waddr = 12'd0; csr_wdata = 64'd0; excep_cause = 64'd0; excep_tval = 64'd0;
        commit_pc = 64'd0; commit_instr = 32'd0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        commit_valid = 1'b1; csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
        commit_instr = 32'h0000_0073;
        step();
        idle();
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [63:0] exp);
        csr_raddr = a;
        #1;
        check(name, csr_rdata, exp);
    endtask

    initial begin
        reset = 1'b0;
        csr_raddr = 12'd0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Reset state and mcycle counting
        repeat (10) step();
        check("reset_priv", {62'd0, priv_mode}, 64'd3);
        check("reset_rv", {63'd0, redirect_valid}, 64'd0);
        peek("mcycle_10", 12'hb00, 64'd10);
        peek("reset_mstatus", 12'h300, 64'd0);
        peek("reset_mtvec", 12'h305, 64'd0);

        // mstatus write masking and sstatus view
        csr_write(12'h300, {64{1'b1}});
        peek("mstatus_ones", 12'h300, 64'h8000_0000_007e_79bb);
        peek("sstatus_view", 12'h100, 64'h8000_0000_0000_6000);
        csr_write(12'h302, {64{1'b1}});
        peek("medeleg_ro", 12'h302, 64'd0);
        peek("mhartid", 12'hf14, 64'd0);
        csr_write(12'h344, {64{1'b1}});
        peek("mip_mask", 12'h344, 64'h333);

        // ecall trap entry
        csr_write(12'h305, 64'h8000_0103);
        peek("mtvec_bit1", 12'h305, 64'h8000_0101);
        commit_valid = 1'b1; excep_en = 1'b1; excep_cause = 64'd11; commit_pc = 64'h8000_0010;
        step();
        idle();
        check("trap_rv", {63'd0, redirect_valid}, 64'd1);
        check("trap_rpc", redirect_pc, 64'h8000_0100);
        peek("trap_mepc", 12'h341, 64'h8000_0010);
        peek("trap_mcause", 12'h342, 64'd11);
        peek("trap_mstatus", 12'h300, 64'h8000_0000_007e_79b3);
        csr_write(12'h340, 64'h1234);  // presented during redirect: dropped
        check("drop_rv", {63'd0, redirect_valid}, 64'd0);
        peek("drop_mscratch", 12'h340, 64'd0);

        // mret to U-mode
        csr_write(12'h300, 64'd0);
        csr_write(12'h341, 64'h8000_0200);
        commit_valid = 1'b1; mret = 1'b1;
        step();
        idle();
        check("mret_rpc", redirect_pc, 64'h8000_0200);
        check("mret_priv", {62'd0, priv_mode}, 64'd0);
        peek("mret_mstatus", 12'h300, 64'h80);
        step();

        // Privilege fault in U-mode, then a commit in the redirect cycle
        commit_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 64'hdead;
        commit_instr = 32'h3052_9073; commit_pc = 64'h8000_0300;
        step();
        idle();
        check("pfault_rpc", redirect_pc, 64'h8000_0100);
        check("pfault_priv", {62'd0, priv_mode}, 64'd3);
        csr_write(12'h340, 64'h55);
        peek("pfault_mtvec", 12'h305, 64'h8000_0101);
        peek("pfault_mcause", 12'h342, 64'd2);
        peek("pfault_mtval", 12'h343, 64'h3052_9073);
        peek("pfault_drop", 12'h340, 64'd0);

        // mcycle load, then mret beats a same-cycle mepc write
        csr_write(12'hb00, 64'h100);
        peek("mcycle_load", 12'hb00, 64'h100);
        step();
        peek("mcycle_next", 12'hb00, 64'h101);
        commit_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 64'h5555; mret = 1'b1;
        step();
        idle();
        check("mret_old_mepc", redirect_pc, 64'h8000_0300);
        peek("mepc_kept", 12'h341, 64'h8000_0300);
        step();

        // Reset asserted in the middle of a redirect
        commit_valid = 1'b1; excep_en = 1'b1; excep_cause = 64'd8;
        step();
        idle();
        check("pre_reset_rv", {63'd0, redirect_valid}, 64'd1);
        #1 reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_rv", {63'd0, redirect_valid}, 64'd0);
        check("async_reset_priv", {62'd0, priv_mode}, 64'd3);
        check("async_reset_rpc", redirect_pc, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized commits
        for (int i = 0; i < 3000; i++) begin
            commit_valid = ($urandom_range(3) != 0);
            csr_we       = $urandom_range(1);
            csr_waddr    = addr_tbl[$urandom_range(19)];
            csr_wdata    = ($urandom_range(7) == 0) ? {64{1'b1}} : {$urandom, $urandom};
            excep_en     = ($urandom_range(7) == 0);
            excep_cause  = {$urandom, $urandom};
            excep_tval   = {$urandom, $urandom};
            mret         = ($urandom_range(7) == 0);
            commit_pc    = {$urandom, $urandom};
            commit_instr = $urandom;
            csr_raddr    = addr_tbl[$urandom_range(19)];
            step();
        end
        idle();
        repeat (3) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Commit-side CSR file and trap sequencer. It consumes the retiring instruction from the writeback stage and owns all machine- and supervisor-level CSRs and the privilege mode. It commits CSR writes, enters traps and executes mret. On a trap or mret it issues a one-cycle redirect/flush to fetch. It also serves combinational CSR reads to decode.

Parameters:
HARTID, 0, value returned by mhartid (0xf14)
RESET_PC_MODE, 2'b11, privilege mode after reset (MODE_M)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
commit_valid  in  1  writeback slot holds a retiring instruction
commit_pc  in  64  pc of retiring instruction
commit_instr  in  32  raw instruction bits (used as illegal-instr tval)
csr_we  in  1  retiring instruction writes a CSR
csr_waddr  in  12  CSR address to write
csr_wdata  in  64  final write value (set/clear already resolved upstream)
excep_en  in  1  retiring instruction raises an exception
excep_cause  in  64  mcause value for the exception
excep_tval  in  64  mtval value for the exception
mret  in  1  retiring instruction is mret
csr_raddr  in  12  decode-side read address
csr_rdata  out  64  decode-side read data (combinational)
priv_mode  out  2  current privilege mode
redirect_valid  out  1  one-cycle flush/redirect pulse
redirect_pc  out  64  redirect target, valid with redirect_valid
satp_out  out  64  current satp for translation logic

Behaviour:
- Reset (reset=0, async): all CSRs 0; priv_mode=RESET_PC_MODE; redirect_valid=0; redirect_pc=0.
- Read path: csr_rdata is a pure mux on csr_raddr. Unimplemented addresses read 0. mhartid reads HARTID.
  - sstatus reads mstatus & 0x800000030001e000.
  - mip reads mip & 0x333.
  - medeleg/mideleg always read 0.
  - mstatus.sd reads 1 iff fs==3 or xs==3.
- mcycle: increments by 1 every cycle with wrap at 2^64. A committed write to mcycle loads csr_wdata instead; there is no increment that cycle.
- An event is accepted only when commit_valid=1 and redirect_valid=0. Commits arriving during the redirect cycle are dropped, because that slot is being flushed.
- Privilege check: csr_we with csr_waddr[9:8] > priv_mode is converted to an exception. The exception uses cause 2 and tval = {32'b0, commit_instr}. The write is discarded.
- Event priority: exception (incl. privilege-check exception) > mret > CSR write. A lower-priority action in the same commit is discarded.
- Write masking:
  - mstatus: new = (old & ~0x7e79bb) | (wdata & 0x7e79bb).
  - sstatus: the same merge into mstatus using mask 0x800000030001e000 minus the sd bit.
  - mtvec: wdata & ~2.
  - mip: masked by 0x333.
  - medeleg/mideleg: writes ignored.
  - satp/s-CSRs/others: full 64-bit write.
- Trap entry, on the cycle after acceptance:
  - mepc=commit_pc, mcause=cause, mtval=tval.
  - mstatus.mpie=mie, mstatus.mie=0, mstatus.mpp=priv_mode.
  - priv_mode=M.
  - redirect_valid=1, redirect_pc={mtvec[63:2],2'b00}. Direct mode only; mtvec mode bits are ignored for the target.
- mret, on the cycle after acceptance:
  - priv_mode=mpp, mie=mpie, mpie=1, mpp=MODE_U.
  - redirect_valid=1, redirect_pc=mepc, using the mepc value before this cycle.
- redirect_valid is a strict one-cycle pulse. Back-to-back events are impossible because of the drop rule above.
- CSR writes take effect on the next clock edge. A decode read of the same address in the commit cycle returns the old value; forwarding is upstream's job.
- Reset asserted mid-redirect clears redirect_valid immediately.

Test Plan:
- Reset release, idle 10 cycles -> priv_mode=3, redirect_valid=0, csr_rdata(0xb00) = 9 or 10 depending on sample edge; all other CSRs read 0.
- Commit csrrw mstatus wdata=all-ones -> mstatus reads 0x7e79bb | sd (sd=1, fs=3); sstatus reads 0x800000000001e000 masked accordingly.
- Commit ecall excep_cause=11 at pc 0x80000010 with mtvec=0x80000103 and mie=1 -> next cycle: redirect_valid=1, redirect_pc=0x80000100, mepc=0x80000010, mcause=11, mie=0, mpie=1, mpp=3.
- Set mpp=0, mepc=0x80000200, commit mret -> redirect_pc=0x80000200, priv_mode=0, mpie=1, mpp=0.
- In U-mode, commit csr_we to 0x305 -> mtvec unchanged, trap with mcause=2, mtval=commit_instr; commit presented in the redirect cycle -> ignored.
- Same-cycle csr_we to mepc with mret -> write dropped, redirect uses old mepc; mcycle write 0x100 -> reads 0x101 the following cycle.
